// File: rtl/audio_clk_pkg.sv
// Shared types and elaboration-time helpers for the fractional audio clock generator.
package audio_clk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

  localparam int DEF_REF_CLK     = 18432000;
  localparam int DEF_SAMPLE_RATE = 16000;
  localparam int DEF_SLOT_W      = 16;
  localparam int DEF_RATIO_W     = 4;

  // Base BCK half-period in reference cycles (four half-periods per slot bit pair of channels).
  function automatic int calc_half(input int ref_clk, input int sample_rate, input int slot_w);
    return ref_clk / (sample_rate * slot_w * 4);
  endfunction

  function automatic bit half_exact(input int ref_clk, input int sample_rate, input int slot_w);
    return (ref_clk % (sample_rate * slot_w * 4)) == 0;
  endfunction

  function automatic int acc_width(input int half, input int ratio_w);
    return $clog2(half * ((1 << ratio_w) - 1)) + 1;
  endfunction

  localparam int ACC_W_DEF =
    acc_width(calc_half(DEF_REF_CLK, DEF_SAMPLE_RATE, DEF_SLOT_W), DEF_RATIO_W);

endpackage

// File: rtl/audio_clk_gen_frac_if.sv
// Configuration handshake between the controlling logic and the clock generator.
interface audio_clk_gen_frac_if #(
  parameter int RATIO_W = 4,
  parameter int XDIV_W  = 3
);
  logic               iCFG_VALID;
  logic               oCFG_READY;
  logic [RATIO_W-1:0] iNUM;
  logic [RATIO_W-1:0] iDEN;
  logic [XDIV_W-1:0]  iXDIV;
  logic               oCFG_ERR;

  modport master (output iCFG_VALID, iNUM, iDEN, iXDIV, input oCFG_READY, oCFG_ERR);
  modport slave  (input iCFG_VALID, iNUM, iDEN, iXDIV, output oCFG_READY, oCFG_ERR);
endinterface

// File: rtl/frac_toggle_div.sv
// Bresenham toggle divider: output toggles whenever the accumulated num crosses half*den.
module frac_toggle_div #(
  parameter int NUM_W  = 4,
  parameter int DEN_W  = 4,
  parameter int HALF_W = 5,
  parameter int ACC_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [NUM_W-1:0]  i_num,
  input  logic [DEN_W-1:0]  i_den,
  input  logic [HALF_W-1:0] i_half,
  output logic              o_tog,
  output logic              o_fall,
  output logic              o_fall_evt
);
  logic [ACC_W-1:0] r_acc;
  logic             r_tog, r_fall;
  logic [ACC_W-1:0] w_sum, w_thr;
  logic             w_hit;

  assign w_thr      = ACC_W'(i_half) * ACC_W'(i_den);
  assign w_sum      = r_acc + ACC_W'(i_num);
  assign w_hit      = i_en && !i_clr && (w_sum >= w_thr);
  // Lets the parent act on a falling edge in the same clock as the output changes.
  assign o_fall_evt = w_hit && r_tog;
  assign o_tog      = r_tog;
  assign o_fall     = r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_tog  <= 1'b0;
      r_fall <= 1'b0;
    end else if (!i_en || i_clr) begin
      r_acc  <= '0;
      r_tog  <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= o_fall_evt;
      if (w_hit) begin
        r_acc <= w_sum - w_thr;
        r_tog <= ~r_tog;
      end else begin
        r_acc <= w_sum;
      end
    end
  end
endmodule

// File: rtl/audio_clk_gen_frac.sv
// I2S-style XCK/BCK/LRCK generator with run-time rational speed, switched only at frame boundaries.
module audio_clk_gen_frac
  import audio_clk_pkg::*;
#(
  parameter int REF_CLK     = DEF_REF_CLK,
  parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
  parameter int SLOT_W      = DEF_SLOT_W,
  parameter int RATIO_W     = DEF_RATIO_W,
  parameter int XDIV_W      = 3
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iEN,
  audio_clk_gen_frac_if.slave  cfg,
  output logic                 oAUD_XCK,
  output logic                 oAUD_BCK,
  output logic                 oAUD_LRCK,
  output logic                 oBCK_FALL,
  output logic                 oFRAME_START
);
  localparam int HALF   = calc_half(REF_CLK, SAMPLE_RATE, SLOT_W);
  localparam int ACC_W  = acc_width(HALF, RATIO_W);
  localparam int HALF_W = $clog2(HALF + 1);
  localparam int CNT_W  = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);

  if (!half_exact(REF_CLK, SAMPLE_RATE, SLOT_W)) begin : g_bad_half
    $error("REF_CLK is not an exact multiple of SAMPLE_RATE*SLOT_W*4");
  end

  state_e             r_state;
  logic [RATIO_W-1:0] r_num, r_den, r_pnum, r_pden;
  logic [XDIV_W-1:0]  r_xdiv, r_pxdiv;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_lrck, r_frame, r_err;

  logic               w_run, w_xfer, w_cfg_ok, w_bound, w_leave, w_clr;
  logic               w_fall_evt, w_frame_evt;
  logic [ACC_W-1:0]   w_lim;
  logic [XDIV_W:0]    w_xden;
  logic               w_xck_fall_unused, w_xck_evt_unused;

  assign w_run    = (r_state != IDLE);
  assign w_xfer   = cfg.iCFG_VALID && cfg.oCFG_READY;
  assign w_lim    = ACC_W'(HALF) * ACC_W'(cfg.iDEN);
  assign w_cfg_ok = (|cfg.iNUM) && (|cfg.iDEN) && (ACC_W'(cfg.iNUM) <= w_lim);
  assign w_bound  = w_run && r_frame;
  assign w_leave  = w_bound && !iEN;
  // Dividers restart from zero whenever a new ratio lands or the block stops.
  assign w_clr    = w_bound && (w_leave || (r_state == PEND));
  assign w_frame_evt = w_fall_evt && (r_cnt == CNT_LAST) && r_lrck;
  assign w_xden   = {1'b0, r_xdiv} + (XDIV_W+1)'(1);

  assign cfg.oCFG_READY = (r_state != PEND);
  assign cfg.oCFG_ERR   = r_err;
  assign oAUD_LRCK      = r_lrck;
  assign oFRAME_START   = r_frame;

  frac_toggle_div #(.NUM_W(RATIO_W), .DEN_W(RATIO_W), .HALF_W(HALF_W), .ACC_W(ACC_W)) u_bck (
    .i_clk(iCLK), .i_rst_n(iRST_N), .i_en(w_run), .i_clr(w_clr),
    .i_num(r_num), .i_den(r_den), .i_half(HALF_W'(HALF)),
    .o_tog(oAUD_BCK), .o_fall(oBCK_FALL), .o_fall_evt(w_fall_evt)
  );

  // num = half = 1 turns the same divider into a plain divide-by-(xdiv+1) toggler.
  frac_toggle_div #(.NUM_W(1), .DEN_W(XDIV_W+1), .HALF_W(1), .ACC_W(XDIV_W+2)) u_xck (
    .i_clk(iCLK), .i_rst_n(iRST_N), .i_en(w_run), .i_clr(w_clr),
    .i_num(1'b1), .i_den(w_xden), .i_half(1'b1),
    .o_tog(oAUD_XCK), .o_fall(w_xck_fall_unused), .o_fall_evt(w_xck_evt_unused)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= IDLE;
      r_num   <= RATIO_W'(1);
      r_den   <= RATIO_W'(1);
      r_xdiv  <= '0;
      r_pnum  <= '0;
      r_pden  <= '0;
      r_pxdiv <= '0;
      r_cnt   <= '0;
      r_lrck  <= 1'b0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_cfg_ok;

      if (!w_run || w_clr) begin
        r_cnt   <= '0;
        r_lrck  <= 1'b0;
        r_frame <= 1'b0;
      end else begin
        r_frame <= w_frame_evt;
        if (w_fall_evt) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_lrck <= ~r_lrck;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      case (r_state)
        IDLE: begin
          if (w_xfer && w_cfg_ok) begin
            r_num  <= cfg.iNUM;
            r_den  <= cfg.iDEN;
            r_xdiv <= cfg.iXDIV;
          end
          if (iEN) r_state <= RUN;
        end
        RUN: begin
          if (w_leave) begin
            r_state <= IDLE;
            if (w_xfer && w_cfg_ok) begin
              r_num  <= cfg.iNUM;
              r_den  <= cfg.iDEN;
              r_xdiv <= cfg.iXDIV;
            end
          end else if (w_xfer && w_cfg_ok) begin
            r_pnum  <= cfg.iNUM;
            r_pden  <= cfg.iDEN;
            r_pxdiv <= cfg.iXDIV;
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_bound) begin
            r_num   <= r_pnum;
            r_den   <= r_pden;
            r_xdiv  <= r_pxdiv;
            r_state <= iEN ? RUN : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_clk_gen_frac.sv
// Directed bench for audio_clk_gen_frac: periods, handshake, frame-boundary switching, stop and reset.
module tb_audio_clk_gen_frac;
  logic iCLK = 1'b0;
  logic iRST_N, iEN;
  logic oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START;
  int   n_pass = 0;
  int   n_tot  = 0;

  audio_clk_gen_frac_if #(.RATIO_W(4), .XDIV_W(3)) cfg ();

  audio_clk_gen_frac #(
    .REF_CLK(18432000), .SAMPLE_RATE(16000), .SLOT_W(16), .RATIO_W(4), .XDIV_W(3)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .cfg(cfg),
    .oAUD_XCK(oAUD_XCK), .oAUD_BCK(oAUD_BCK), .oAUD_LRCK(oAUD_LRCK),
    .oBCK_FALL(oBCK_FALL), .oFRAME_START(oFRAME_START)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return oAUD_BCK;
      1:       return oAUD_LRCK;
      default: return oAUD_XCK;
    endcase
  endfunction

  // Cycles until the selected clock changes; -1 if it never does within maxc.
  task automatic wait_chg(input int sel, input int maxc, output int n);
    logic p;
    p = sig(sel);
    n = 0;
    do begin step(); n++; end while (sig(sel) === p && n < maxc);
    if (sig(sel) === p) n = -1;
  endtask

  task automatic wait_fs(input int maxc, output int n);
    n = 0;
    do begin step(); n++; end while (oFRAME_START !== 1'b1 && n < maxc);
    if (oFRAME_START !== 1'b1) n = -1;
  endtask

  task automatic offer(input logic [3:0] num, input logic [3:0] den, input logic [2:0] xd);
    cfg.iNUM = num; cfg.iDEN = den; cfg.iXDIV = xd; cfg.iCFG_VALID = 1'b1;
    step();
    cfg.iCFG_VALID = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    iRST_N = 1'b1; iEN = 1'b0;
    cfg.iCFG_VALID = 1'b0; cfg.iNUM = 4'd1; cfg.iDEN = 4'd1; cfg.iXDIV = 3'd0;
    #2 iRST_N = 1'b0;
    #10;
    n_tot++; if ({oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START, cfg.oCFG_ERR} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START, cfg.oCFG_ERR});
    else n_pass++;
    n_tot++; if (cfg.oCFG_READY !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg.oCFG_READY); else n_pass++;
    step(); step();
    iRST_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START} !== 5'b0) bad++;
    end
    n_tot++; if (bad !== 0) $display("FAIL idle_quiet: %0d active cycles, want 0", bad); else n_pass++;
  endtask

  task automatic test_base();
    int n;
    iEN = 1'b1;
    wait_chg(0, 100, n);
    n_tot++; if (n !== 19) $display("FAIL first_bck_rise: got %0d want 19", n); else n_pass++;
    wait_chg(0, 100, n);
    n_tot++; if (n !== 18) $display("FAIL bck_high_1_1: got %0d want 18", n); else n_pass++;
    n_tot++; if (oBCK_FALL !== 1'b1) $display("FAIL bck_fall_strobe: got %b want 1", oBCK_FALL); else n_pass++;
    step();
    n_tot++; if (oBCK_FALL !== 1'b0) $display("FAIL bck_fall_one_cycle: got %b want 0", oBCK_FALL); else n_pass++;
    wait_chg(0, 100, n);
    n_tot++; if (n !== 17) $display("FAIL bck_low_1_1: got %0d want 17", n); else n_pass++;
    wait_fs(1300, n);
    wait_fs(1300, n);
    n_tot++; if (n !== 1152) $display("FAIL frame_period_1_1: got %0d want 1152", n); else n_pass++;
    n_tot++; if (oAUD_LRCK !== 1'b0) $display("FAIL lrck_left_at_frame: got %b want 0", oAUD_LRCK); else n_pass++;
    wait_chg(1, 700, n);
    n_tot++; if (n !== 576) $display("FAIL lrck_half_1_1: got %0d want 576", n); else n_pass++;
  endtask

  task automatic test_ratio_2_1();
    int n;
    offer(4'd2, 4'd1, 3'd0);
    n_tot++; if (cfg.oCFG_READY !== 1'b0) $display("FAIL pend_ready: got %b want 0", cfg.oCFG_READY); else n_pass++;
    n_tot++; if (cfg.oCFG_ERR !== 1'b0) $display("FAIL valid_no_err: got %b want 0", cfg.oCFG_ERR); else n_pass++;
    wait_fs(700, n);
    n_tot++; if (cfg.oCFG_READY !== 1'b0) $display("FAIL ready_at_boundary: got %b want 0", cfg.oCFG_READY); else n_pass++;
    step();
    n_tot++; if (cfg.oCFG_READY !== 1'b1) $display("FAIL ready_after_apply: got %b want 1", cfg.oCFG_READY); else n_pass++;
    wait_fs(700, n);
    n_tot++; if (n !== 576) $display("FAIL first_frame_2_1: got %0d want 576", n); else n_pass++;
    wait_fs(700, n);
    n_tot++; if (n !== 576) $display("FAIL frame_period_2_1: got %0d want 576", n); else n_pass++;
    wait_chg(0, 40, n);
    n_tot++; if (n !== 9) $display("FAIL bck_high_2_1: got %0d want 9", n); else n_pass++;
    wait_chg(0, 40, n);
    n_tot++; if (n !== 9) $display("FAIL bck_low_2_1: got %0d want 9", n); else n_pass++;
  endtask

  task automatic test_ratio_2_3();
    int n;
    offer(4'd2, 4'd3, 3'd0);
    wait_fs(700, n);
    wait_fs(2000, n);
    wait_chg(0, 60, n);
    n_tot++; if (n !== 27) $display("FAIL bck_high_2_3: got %0d want 27", n); else n_pass++;
    wait_chg(0, 60, n);
    n_tot++; if (n !== 27) $display("FAIL bck_low_2_3: got %0d want 27", n); else n_pass++;
  endtask

  task automatic test_ratio_4_7();
    int n, bad, sum;
    offer(4'd4, 4'd7, 3'd0);
    wait_fs(2000, n);
    wait_fs(2100, n);
    bad = 0; sum = 0;
    for (int i = 0; i < 32; i++) begin
      wait_chg(0, 40, n);
      if (n < 31 || n > 32) bad++;
      sum += n;
    end
    n_tot++; if (bad !== 0) $display("FAIL half_range_4_7: %0d halves outside 31..32", bad); else n_pass++;
    n_tot++; if (sum !== 1008) $display("FAIL avg_4_7: 32 halves took %0d want 1008", sum); else n_pass++;
  endtask

  task automatic test_cfg_err();
    int n, sum;
    offer(4'd0, 4'd1, 3'd0);
    n_tot++; if (cfg.oCFG_ERR !== 1'b1) $display("FAIL err_num0: got %b want 1", cfg.oCFG_ERR); else n_pass++;
    n_tot++; if (cfg.oCFG_READY !== 1'b1) $display("FAIL err_ready: got %b want 1", cfg.oCFG_READY); else n_pass++;
    step();
    n_tot++; if (cfg.oCFG_ERR !== 1'b0) $display("FAIL err_pulse_num0: got %b want 0", cfg.oCFG_ERR); else n_pass++;
    offer(4'd15, 4'd0, 3'd0);
    n_tot++; if (cfg.oCFG_ERR !== 1'b1) $display("FAIL err_den0: got %b want 1", cfg.oCFG_ERR); else n_pass++;
    step();
    n_tot++; if (cfg.oCFG_ERR !== 1'b0) $display("FAIL err_pulse_den0: got %b want 0", cfg.oCFG_ERR); else n_pass++;
    wait_fs(2100, n);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_chg(0, 40, n);
      sum += n;
    end
    n_tot++; if (sum !== 252) $display("FAIL ratio_kept: 8 halves took %0d want 252", sum); else n_pass++;
  endtask

  task automatic test_xdiv();
    int n;
    wait_chg(2, 10, n);
    n_tot++; if (n !== 1) $display("FAIL xck_div0: got %0d want 1", n); else n_pass++;
    offer(4'd4, 4'd7, 3'd3);
    wait_fs(2100, n);
    step();
    wait_chg(2, 20, n);
    n_tot++; if (n !== 4) $display("FAIL xck_first_div3: got %0d want 4", n); else n_pass++;
    wait_chg(2, 20, n);
    n_tot++; if (n !== 4) $display("FAIL xck_half_div3: got %0d want 4", n); else n_pass++;
  endtask

  task automatic test_same_cycle();
    int n;
    wait_fs(2100, n);
    offer(4'd2, 4'd1, 3'd3);
    n_tot++; if (cfg.oCFG_READY !== 1'b0) $display("FAIL same_cycle_pend: got %b want 0", cfg.oCFG_READY); else n_pass++;
    wait_fs(2100, n);
    n_tot++; if (n !== 2015) $display("FAIL same_cycle_deferred: got %0d want 2015", n); else n_pass++;
    wait_fs(700, n);
    n_tot++; if (n !== 577) $display("FAIL same_cycle_applied: got %0d want 577", n); else n_pass++;
  endtask

  task automatic test_en_drop();
    int n, bad;
    repeat (100) step();
    iEN = 1'b0;
    wait_chg(0, 20, n);
    n_tot++; if (!(n >= 1 && n <= 9)) $display("FAIL run_after_en_low: got %0d want 1..9", n); else n_pass++;
    wait_fs(700, n);
    n_tot++; if (oFRAME_START !== 1'b1) $display("FAIL stop_boundary: got %b want 1", oFRAME_START); else n_pass++;
    step();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if ({oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START} !== 5'b0) bad++;
      step();
    end
    n_tot++; if (bad !== 0) $display("FAIL stopped_quiet: %0d active cycles, want 0", bad); else n_pass++;
    n_tot++; if (cfg.oCFG_READY !== 1'b1) $display("FAIL stopped_ready: got %b want 1", cfg.oCFG_READY); else n_pass++;
  endtask

  task automatic test_reset_pend();
    int n;
    iEN = 1'b1;
    wait_fs(700, n);
    n_tot++; if (n !== 577) $display("FAIL restart_frame_2_1: got %0d want 577", n); else n_pass++;
    repeat (20) step();
    offer(4'd2, 4'd3, 3'd0);
    n_tot++; if (cfg.oCFG_READY !== 1'b0) $display("FAIL pend_before_reset: got %b want 0", cfg.oCFG_READY); else n_pass++;
    repeat (30) step();
    #2 iRST_N = 1'b0;
    #1;
    n_tot++; if ({oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START, cfg.oCFG_ERR} !== 6'b0)
      $display("FAIL async_reset_outputs: got %b want 000000", {oAUD_XCK, oAUD_BCK, oAUD_LRCK, oBCK_FALL, oFRAME_START, cfg.oCFG_ERR});
    else n_pass++;
    n_tot++; if (cfg.oCFG_READY !== 1'b1) $display("FAIL async_reset_ready: got %b want 1", cfg.oCFG_READY); else n_pass++;
    step(); step();
    iRST_N = 1'b1;
    wait_chg(0, 100, n);
    n_tot++; if (n !== 19) $display("FAIL post_reset_first: got %0d want 19", n); else n_pass++;
    wait_chg(0, 100, n);
    n_tot++; if (n !== 18) $display("FAIL post_reset_ratio: got %0d want 18", n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_base();
    test_ratio_2_1();
    test_ratio_2_3();
    test_ratio_4_7();
    test_cfg_err();
    test_xdiv();
    test_same_cycle();
    test_en_drop();
    test_reset_pend();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
